// File: rtl/arp_note_voice.sv
// arp_note_voice: one-hot note select driving a square-wave divider shaped by a
// linear attack/sustain/release envelope into a signed 16-bit sample.
module arp_note_voice #(
   parameter int P0 = 95556,
   parameter int P1 = 85131,
   parameter int P2 = 75843,
   parameter int P3 = 71586,
   parameter int P4 = 63776,
   parameter int P5 = 56818,
   parameter int P6 = 50619,
   parameter int P7 = 47778,
   parameter int DIV_WIDTH = 17,
   parameter int ENV_TICK = 1024
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        Enable,
   input  logic        in0,
   input  logic        in1,
   input  logic        in2,
   input  logic        in3,
   input  logic        in4,
   input  logic        in5,
   input  logic        in6,
   input  logic        in7,
   output logic [15:0] Sample,
   output logic        SqOut,
   output logic        Active,
   output logic [2:0]  NoteIdx
);
   localparam int TW = ENV_TICK > 1 ? $clog2(ENV_TICK) : 1;
   localparam logic [DIV_WIDTH-1:0] RL [8] = '{
      DIV_WIDTH'(P0 - 1), DIV_WIDTH'(P1 - 1), DIV_WIDTH'(P2 - 1), DIV_WIDTH'(P3 - 1),
      DIV_WIDTH'(P4 - 1), DIV_WIDTH'(P5 - 1), DIV_WIDTH'(P6 - 1), DIV_WIDTH'(P7 - 1)};
   typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
   state_t state, state_n;
   logic [7:0] level, level_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [DIV_WIDTH-1:0] div, div_n;
   logic sq_n, present, load, step;
   logic [2:0] sel, idx_n;
   logic [15:0] mag;
   assign sel = in0 ? 3'd0 : in1 ? 3'd1 : in2 ? 3'd2 : in3 ? 3'd3 :
                in4 ? 3'd4 : in5 ? 3'd5 : in6 ? 3'd6 : 3'd7;
   assign present = Enable && |{in7, in6, in5, in4, in3, in2, in1, in0};
   assign load = present && (state == IDLE || sel != NoteIdx);
   assign step = tcnt == TW'(ENV_TICK - 1);
   always_comb begin
      state_n = state;
      level_n = level;
      case (state)
         IDLE: begin
            level_n = '0;
            if (present) state_n = ATTACK;
         end
         ATTACK:
            if (!present) state_n = RELEASE;
            else if (step) begin
               if (level == 8'hff) state_n = SUSTAIN;
               else level_n = level + 8'd1;
            end
         SUSTAIN:
            if (!present) state_n = RELEASE;
         default:
            if (present) state_n = ATTACK;
            else if (level == 8'd0) state_n = IDLE;
            else if (step) begin
               level_n = level - 8'd1;
               if (level == 8'd1) state_n = IDLE;
            end
      endcase
      // tcnt is parked at 0 while idle so a fresh attack starts a full tick
      tcnt_n = (state == IDLE || step) ? '0 : tcnt + TW'(1);
      div_n = load ? RL[sel] : div == '0 ? RL[NoteIdx] : div - DIV_WIDTH'(1);
      sq_n = load ? 1'b1 : div == '0 ? ~SqOut : SqOut;
      idx_n = load ? sel : NoteIdx;
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         level <= '0;
         tcnt <= '0;
         div <= '0;
         SqOut <= 1'b0;
         NoteIdx <= '0;
      end else begin
         state <= state_n;
         level <= level_n;
         tcnt <= tcnt_n;
         div <= div_n;
         SqOut <= sq_n;
         NoteIdx <= idx_n;
      end
   end
   assign mag = {1'b0, level, 7'b0};
   assign Sample = SqOut ? mag : -mag;
   assign Active = state != IDLE;
endmodule

// File: tb/tb_arp_note_voice.sv
// tb_arp_note_voice: randomized stimulus against a closed-form reference model,
// expectations queued per edge and compared by an independent monitor.
module tb_arp_note_voice;
   localparam int P [8] = '{3, 5, 4, 7, 2, 6, 9, 8};
   localparam int ET = 2;
   logic CLK = 1'b0;
   logic RESET, Enable, in0, in1, in2, in3, in4, in5, in6, in7;
   logic [15:0] Sample;
   logic SqOut, Active;
   logic [2:0] NoteIdx;
   typedef struct {
      logic [15:0] s;
      logic sq;
      logic act;
      logic [2:0] idx;
   } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   int m_st = 0, m_lvl = 0, m_idx = 0, m_t0 = 0, m_e0 = 0, e = 0;

   arp_note_voice #(.P0(3), .P1(5), .P2(4), .P3(7), .P4(2), .P5(6), .P6(9), .P7(8),
                    .DIV_WIDTH(17), .ENV_TICK(ET)) dut (
      .CLK(CLK), .RESET(RESET), .Enable(Enable),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6), .in7(in7),
      .Sample(Sample), .SqOut(SqOut), .Active(Active), .NoteIdx(NoteIdx));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge-count %0d: got %0h expected %0h", name, checks / 4, act, exp);
      end
   endtask

   // Envelope state as 0 idle, 1 attack, 2 sustain, 3 release; tone phase is derived
   // from the cycle of the last load instead of a running divider.
   task automatic model(input logic rst, input logic en, input logic [7:0] notes);
      int sel;
      bit pres, load, step;
      exp_t x;
      sel = -1;
      for (int i = 7; i >= 0; i--) if (notes[i]) sel = i;
      pres = en && sel >= 0;
      if (rst) begin
         m_st = 0; m_lvl = 0; m_idx = 0;
         m_t0 = e + 1 - 2 * P[0];
      end else begin
         load = pres && (m_st == 0 || sel != m_idx);
         step = e > m_e0 && ((e - m_e0) % ET) == 0;
         case (m_st)
            0: if (pres) begin m_st = 1; m_e0 = e; end
            1: if (!pres) m_st = 3;
               else if (step) begin if (m_lvl == 255) m_st = 2; else m_lvl++; end
            2: if (!pres) m_st = 3;
            default: if (pres) m_st = 1;
               else if (m_lvl == 0) m_st = 0;
               else if (step) begin m_lvl--; if (m_lvl == 0) m_st = 0; end
         endcase
         if (load) begin m_idx = sel; m_t0 = e; end
      end
      x.sq = (((e - m_t0) / P[m_idx]) % 2) == 0;
      x.s = x.sq ? 16'(m_lvl * 128) : 16'(-(m_lvl * 128));
      x.act = m_st != 0;
      x.idx = 3'(m_idx);
      q.push_back(x);
      e++;
   endtask

   task automatic drive(input logic rst, input logic en, input logic [7:0] notes, input int n);
      for (int k = 0; k < n; k++) begin
         RESET = rst;
         Enable = en;
         {in7, in6, in5, in4, in3, in2, in1, in0} = notes;
         model(rst, en, notes);
         @(posedge CLK);
         #1;
      end
   endtask

   always @(negedge CLK) begin
      if (q.size() != 0) begin
         exp_t x;
         x = q.pop_front();
         chk("Sample", Sample, x.s);
         chk("SqOut", 16'(SqOut), 16'(x.sq));
         chk("Active", 16'(Active), 16'(x.act));
         chk("NoteIdx", 16'(NoteIdx), 16'(x.idx));
      end
   end

   initial begin
      drive(1, 1, 8'h01, 2);
      drive(0, 1, 8'h01, 600);
      drive(0, 1, 8'h02, 20);
      drive(0, 1, 8'h00, 310);
      drive(0, 1, 8'h28, 60);
      drive(0, 1, 8'h04, 10);
      drive(0, 0, 8'h04, 600);
      drive(0, 1, 8'h01, 10);
      drive(1, 1, 8'h01, 1);
      for (int s = 0; s < 60; s++) begin
         int kind, len;
         logic [7:0] pat;
         kind = $urandom_range(0, 9);
         len = $urandom_range(0, 1) ? $urandom_range(1, 8) : $urandom_range(100, 700);
         pat = $urandom_range(0, 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
         if (kind == 0) drive(1, 1, pat, $urandom_range(1, 2));
         else if (kind < 3) drive(0, 1, 8'h00, len);
         else drive(0, $urandom_range(0, 7) != 0, pat, len);
      end
      repeat (3) @(negedge CLK);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
